// File: rtl/sme_match_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : sme_match_collector_if
//  Description : Match-port and summary-port bundle between the Pigasus SME,
//                the match collector and the core-side result path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sme_match_collector_if #(
    parameter int RULE_W      = 16,
    parameter int MAX_MATCHES = 8,
    parameter int STATE_W     = 64,
    parameter int CNT_W       = 8
);
    // SME match stream
    logic [RULE_W-1:0]             match_rule_ID;
    logic                          match_valid;
    logic                          match_last;
    logic [STATE_W-1:0]            preamble_state_in;
    logic                          match_release;

    // Packed per-packet summary
    logic                          sum_valid;
    logic                          sum_ready;
    logic [MAX_MATCHES*RULE_W-1:0] sum_rule_ids;
    logic [CNT_W-1:0]              sum_count;
    logic                          sum_overflow;
    logic [STATE_W-1:0]            sum_state;

    // Statistics
    logic [31:0]                   stat_pkts;
    logic [31:0]                   stat_matches;

    // Producer side: the SME plus the summary consumer
    modport master (
        output match_rule_ID, match_valid, match_last, preamble_state_in, sum_ready,
        input  match_release, sum_valid, sum_rule_ids, sum_count, sum_overflow,
        input  sum_state, stat_pkts, stat_matches
    );

    // Collector side
    modport slave (
        input  match_rule_ID, match_valid, match_last, preamble_state_in, sum_ready,
        output match_release, sum_valid, sum_rule_ids, sum_count, sum_overflow,
        output sum_state, stat_pkts, stat_matches
    );
endinterface
`default_nettype wire

// File: rtl/sme_match_collector.sv
`default_nettype none
// ============================================================================
//  Module      : sme_match_collector
//  Description : Gathers the SME matched rule IDs of one packet into a packed
//                summary word and hands it to the core with valid/ready,
//                backpressuring the SME while a summary is waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module sme_match_collector #(
    parameter int RULE_W      = 16,
    parameter int MAX_MATCHES = 8,
    parameter int STATE_W     = 64,
    parameter int CNT_W       = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    sme_match_collector_if.slave    bus
);
    localparam int               c_IDS_W   = MAX_MATCHES * RULE_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [CNT_W-1:0]     r_acc_cnt;
    logic                 r_acc_ovf;
    logic [c_IDS_W-1:0]   r_acc_ids;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_ovf_nxt;
    logic [c_IDS_W-1:0]   w_ids_nxt;

    logic [c_IDS_W-1:0]   r_sum_ids;
    logic [CNT_W-1:0]     r_sum_cnt;
    logic                 r_sum_ovf;
    logic [STATE_W-1:0]   r_sum_state;
    logic [31:0]          r_stat_pkts;
    logic [31:0]          r_stat_matches;

    logic                 w_release;
    logic                 w_accept;
    logic                 w_accept_last;
    logic                 w_id_nz;
    logic                 w_slot_free;

    // A pending summary blocks the SME unless the core takes it this cycle
    assign w_release     = (r_state == ST_IDLE) || bus.sum_ready;
    assign w_accept      = bus.match_valid && w_release;
    assign w_accept_last = w_accept && bus.match_last;
    // Rule ID 0 only marks an empty packet and is never stored or counted
    assign w_id_nz       = |bus.match_rule_ID;
    assign w_slot_free   = 32'(r_acc_cnt) < MAX_MATCHES;

    // Accumulator after the current beat, also used to load the summary on last
    always_comb begin
        w_ids_nxt = r_acc_ids;
        w_cnt_nxt = r_acc_cnt;
        w_ovf_nxt = r_acc_ovf;
        if (w_accept && w_id_nz) begin
            if (w_slot_free) begin
                for (int k = 0; k < MAX_MATCHES; k++) begin
                    if (r_acc_cnt == CNT_W'(k)) begin
                        w_ids_nxt[k*RULE_W +: RULE_W] = bus.match_rule_ID;
                    end
                end
            end else begin
                w_ovf_nxt = 1'b1;
            end
            if (r_acc_cnt != c_CNT_MAX) begin
                w_cnt_nxt = r_acc_cnt + CNT_W'(1);
            end
        end
    end

    // Next state: a last beat accepted while pending reloads back-to-back
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept_last) w_state_nxt = ST_PEND;
            ST_PEND: begin
                if (w_accept_last)      w_state_nxt = ST_PEND;
                else if (bus.sum_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Per-packet accumulator, cleared once the packet has been summarised
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_ids <= '0;
            r_acc_cnt <= '0;
            r_acc_ovf <= 1'b0;
        end else if (w_accept_last) begin
            r_acc_ids <= '0;
            r_acc_cnt <= '0;
            r_acc_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc_ids <= w_ids_nxt;
            r_acc_cnt <= w_cnt_nxt;
            r_acc_ovf <= w_ovf_nxt;
        end
    end

    // Summary registers only change on a last beat, so they hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_ids   <= '0;
            r_sum_cnt   <= '0;
            r_sum_ovf   <= 1'b0;
            r_sum_state <= '0;
        end else if (w_accept_last) begin
            r_sum_ids   <= w_ids_nxt;
            r_sum_cnt   <= w_cnt_nxt;
            r_sum_ovf   <= w_ovf_nxt;
            r_sum_state <= bus.preamble_state_in;
        end
    end

    // Wrapping packet and match statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_pkts    <= '0;
            r_stat_matches <= '0;
        end else begin
            if (w_accept_last)       r_stat_pkts    <= r_stat_pkts + 32'd1;
            if (w_accept && w_id_nz) r_stat_matches <= r_stat_matches + 32'd1;
        end
    end

    assign bus.match_release = w_release;
    assign bus.sum_valid     = (r_state == ST_PEND);
    assign bus.sum_rule_ids  = r_sum_ids;
    assign bus.sum_count     = r_sum_cnt;
    assign bus.sum_overflow  = r_sum_ovf;
    assign bus.sum_state     = r_sum_state;
    assign bus.stat_pkts     = r_stat_pkts;
    assign bus.stat_matches  = r_stat_matches;
endmodule
`default_nettype wire

// File: tb/tb_sme_match_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sme_match_collector
//  Description : Directed vector table plus reset sequences for the SME
//                match collector (RULE_W=16, MAX_MATCHES=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sme_match_collector;
    localparam logic [127:0] c_IDS8 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;

    typedef struct {
        logic         v;
        logic         l;
        logic [15:0]  id;
        logic [63:0]  st;
        logic         rdy;
        logic         e_rel;
        logic         e_val;
        logic         chk;
        logic [7:0]   e_cnt;
        logic         e_ovf;
        logic [127:0] e_ids;
        logic [63:0]  e_st;
        logic [31:0]  e_pkts;
        logic [31:0]  e_m;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t tbl[$];

    sme_match_collector_if #(.RULE_W(16), .MAX_MATCHES(8), .STATE_W(64), .CNT_W(8)) bus ();

    sme_match_collector #(.RULE_W(16), .MAX_MATCHES(8), .STATE_W(64), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic l, logic [15:0] id, logic [63:0] st, logic rdy,
                                logic e_rel, logic e_val, logic chk, logic [7:0] e_cnt,
                                logic e_ovf, logic [127:0] e_ids, logic [63:0] e_st,
                                int p, int m);
        vec_t r;
        r.v = v; r.l = l; r.id = id; r.st = st; r.rdy = rdy;
        r.e_rel = e_rel; r.e_val = e_val; r.chk = chk; r.e_cnt = e_cnt;
        r.e_ovf = e_ovf; r.e_ids = e_ids; r.e_st = e_st;
        r.e_pkts = 32'(p); r.e_m = 32'(m);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_summary(input logic [7:0] cnt, input logic ovf,
                                 input logic [127:0] ids, input logic [63:0] st);
        check("sum_count", 128'(bus.sum_count), 128'(cnt));
        check("sum_overflow", 128'(bus.sum_overflow), 128'(ovf));
        check("sum_rule_ids", bus.sum_rule_ids, ids);
        check("sum_state", 128'(bus.sum_state), 128'(st));
    endtask

    // Drive one vector mid-cycle, check release before the edge and state after it
    task automatic step(input vec_t t);
        @(negedge clk);
        bus.match_valid       = t.v;
        bus.match_last        = t.l;
        bus.match_rule_ID     = t.id;
        bus.preamble_state_in = t.st;
        bus.sum_ready         = t.rdy;
        #1;
        check("match_release", 128'(bus.match_release), 128'(t.e_rel));
        @(posedge clk);
        #1;
        check("sum_valid", 128'(bus.sum_valid), 128'(t.e_val));
        check("stat_pkts", 128'(bus.stat_pkts), 128'(t.e_pkts));
        check("stat_matches", 128'(bus.stat_matches), 128'(t.e_m));
        if (t.chk) check_summary(t.e_cnt, t.e_ovf, t.e_ids, t.e_st);
    endtask

    initial begin
        int p;
        int m;
        checks = 0;
        errors = 0;
        p = 0;
        m = 0;

        // ---------------- vector table ----------------
        // Two-ID packet
        m = 1;
        tbl.push_back(mk(1, 0, 16'h0011, 64'h0, 1, 1, 0, 0, 0, 0, 0, 0, p, m));
        m = 2; p = 1;
        tbl.push_back(mk(1, 1, 16'h0022, 64'hA5A5_0000_0000_0001, 1, 1, 1, 1, 8'd2, 0,
                         128'h0022_0011, 64'hA5A5_0000_0000_0001, p, m));
        // Empty packet, back-to-back with the previous summary
        p = 2;
        tbl.push_back(mk(1, 1, 16'h0000, 64'h2, 1, 1, 1, 1, 8'd0, 0, 128'h0, 64'h2, p, m));
        // Ten IDs: overflow
        for (int k = 1; k <= 9; k++) begin
            m++;
            tbl.push_back(mk(1, 0, 16'(k), 64'h0, 1, 1, 0, 0, 0, 0, 0, 0, p, m));
        end
        m++; p++;
        tbl.push_back(mk(1, 1, 16'd10, 64'h3, 1, 1, 1, 1, 8'd10, 1, c_IDS8, 64'h3, p, m));
        // Exactly eight IDs: all slots, no overflow
        for (int k = 1; k <= 7; k++) begin
            m++;
            tbl.push_back(mk(1, 0, 16'(k), 64'h0, 1, 1, 0, 0, 0, 0, 0, 0, p, m));
        end
        m++; p++;
        tbl.push_back(mk(1, 1, 16'd8, 64'h4, 1, 1, 1, 1, 8'd8, 0, c_IDS8, 64'h4, p, m));
        // Nine IDs: first overflow
        for (int k = 1; k <= 8; k++) begin
            m++;
            tbl.push_back(mk(1, 0, 16'(k), 64'h0, 1, 1, 0, 0, 0, 0, 0, 0, p, m));
        end
        m++; p++;
        tbl.push_back(mk(1, 1, 16'd9, 64'h5, 1, 1, 1, 1, 8'd9, 1, c_IDS8, 64'h5, p, m));
        // Last beat every cycle: one summary per cycle, release stays high
        for (int j = 1; j <= 3; j++) begin
            m++; p++;
            tbl.push_back(mk(1, 1, 16'(j << 8), 64'(j), 1, 1, 1, 1, 8'd1, 0,
                             128'(j << 8), 64'(j), p, m));
        end
        tbl.push_back(mk(0, 0, 16'h0, 64'h0, 1, 1, 0, 0, 0, 0, 0, 0, p, m));
        // Backpressure: first summary held, second beat waits for sum_ready
        m++; p++;
        tbl.push_back(mk(1, 1, 16'h0055, 64'h55, 0, 1, 1, 1, 8'd1, 0, 128'h55, 64'h55, p, m));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mk(1, 1, 16'h0066, 64'h66, 0, 0, 1, 1, 8'd1, 0, 128'h55, 64'h55, p, m));
        end
        m++; p++;
        tbl.push_back(mk(1, 1, 16'h0066, 64'h66, 1, 1, 1, 1, 8'd1, 0, 128'h66, 64'h66, p, m));
        tbl.push_back(mk(0, 0, 16'h0, 64'h0, 1, 1, 0, 0, 0, 0, 0, 0, p, m));

        // ---------------- reset ----------------
        rst_n                 = 1'b0;
        bus.match_valid       = 1'b0;
        bus.match_last        = 1'b0;
        bus.match_rule_ID     = '0;
        bus.preamble_state_in = '0;
        bus.sum_ready         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("release_in_reset", 128'(bus.match_release), 128'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_valid", 128'(bus.sum_valid), 128'd0);
        check("reset_release", 128'(bus.match_release), 128'd1);
        check("reset_pkts", 128'(bus.stat_pkts), 128'd0);
        check("reset_matches", 128'(bus.stat_matches), 128'd0);
        check_summary(8'd0, 1'b0, 128'h0, 64'h0);

        foreach (tbl[i]) step(tbl[i]);

        // ---------------- asynchronous reset mid-packet ----------------
        for (int k = 1; k <= 3; k++) begin
            m++;
            step(mk(1, 0, 16'(k + 16'h30), 64'h0, 1, 1, 0, 0, 0, 0, 0, 0, p, m));
        end
        #2;
        bus.match_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_valid", 128'(bus.sum_valid), 128'd0);
        check("async_release", 128'(bus.match_release), 128'd1);
        check("async_pkts", 128'(bus.stat_pkts), 128'd0);
        check("async_matches", 128'(bus.stat_matches), 128'd0);
        check_summary(8'd0, 1'b0, 128'h0, 64'h0);
        #1;
        rst_n = 1'b1;
        step(mk(1, 1, 16'h0077, 64'h77, 1, 1, 1, 1, 8'd1, 0, 128'h77, 64'h77, 1, 1));
        step(mk(0, 0, 16'h0, 64'h0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
